// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer: TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB onto the shared TLB entry array.
// Latency: accept->done 2 cycles for non-INVTLB ops, TLB_ENTRY_NUM+1 cycles for an INVTLB walk.
// Backpressure: req_ready only in IDLE; busy holds the pipeline until the DONE cycle has passed.

package tlb_maint_pkg;
    typedef struct packed {
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic        g;
        logic [9:0]  asid;
        logic        e;
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;
endpackage

module tlb_maint_ctrl
    import tlb_maint_pkg::*;
#(
    parameter int TLB_ENTRY_NUM = 16,
    localparam int IDX_W = $clog2(TLB_ENTRY_NUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [4:0]       inv_op,
    input  logic [9:0]       inv_asid,
    input  logic [31:0]      inv_va,
    input  logic [IDX_W-1:0] csr_idx,
    input  tlb_entry_t       csr_entry,
    input  logic             srch_found,
    input  logic [IDX_W-1:0] srch_idx,
    input  tlb_entry_t       entrys [TLB_ENTRY_NUM],
    output logic             tlb_we,
    output logic [IDX_W-1:0] tlb_widx,
    output tlb_entry_t       tlb_wentry,
    output tlb_entry_t       rd_entry,
    output logic             res_found,
    output logic [IDX_W-1:0] res_idx,
    output logic             done,
    output logic             ine,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRY_NUM - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WALK, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q;
    logic [4:0]       inv_op_q;
    logic [9:0]       inv_asid_q;
    logic [18:0]      inv_vppn_q;
    logic [IDX_W-1:0] csr_idx_q;
    tlb_entry_t       csr_entry_q;
    logic [IDX_W-1:0] walk_cnt_q, walk_cnt_d;
    logic [IDX_W-1:0] fill_cnt_q;
    logic             tlb_we_q, tlb_we_d;
    logic [IDX_W-1:0] tlb_widx_q, tlb_widx_d;
    tlb_entry_t       tlb_wentry_q, tlb_wentry_d;
    tlb_entry_t       rd_entry_q, rd_entry_d;
    logic             res_found_q, res_found_d;
    logic [IDX_W-1:0] res_idx_q, res_idx_d;
    logic             done_q, done_d;
    logic             ine_q, ine_d;
    logic             accept;
    tlb_entry_t       walk_ent;
    logic             va_match;
    logic             asid_match;
    logic             inv_hit;
    logic             unused_va_low;

    // Page offset bits never take part in an INVTLB VA compare.
    assign unused_va_low = ^inv_va[12:0];

    assign req_ready = (state_q == S_IDLE);
    assign busy      = ~req_ready;
    assign accept    = req_valid & req_ready;

    assign tlb_we     = tlb_we_q;
    assign tlb_widx   = tlb_widx_q;
    assign tlb_wentry = tlb_wentry_q;
    assign rd_entry   = rd_entry_q;
    assign res_found  = res_found_q;
    assign res_idx    = res_idx_q;
    assign done       = done_q;
    assign ine        = ine_q;

    // INVTLB match for the entry under the walk pointer; the compare width follows that entry's page size.
    always_comb begin
        walk_ent   = entrys[walk_cnt_q];
        asid_match = (walk_ent.asid == inv_asid_q);
        if (walk_ent.ps == 6'd21) begin
            va_match = (walk_ent.vppn[18:9] == inv_vppn_q[18:9]);
        end else begin
            va_match = (walk_ent.vppn == inv_vppn_q);
        end
        case (inv_op_q)
            5'd0, 5'd1: inv_hit = 1'b1;
            5'd2:       inv_hit = walk_ent.g;
            5'd3:       inv_hit = ~walk_ent.g;
            5'd4:       inv_hit = ~walk_ent.g & asid_match;
            5'd5:       inv_hit = ~walk_ent.g & asid_match & va_match;
            5'd6:       inv_hit = (walk_ent.g | asid_match) & va_match;
            default:    inv_hit = 1'b0;
        endcase
    end

    // Next state and next values of the registered outputs; write/done/ine are pulses computed one cycle ahead.
    always_comb begin
        state_d      = state_q;
        walk_cnt_d   = walk_cnt_q;
        tlb_we_d     = 1'b0;
        tlb_widx_d   = tlb_widx_q;
        tlb_wentry_d = tlb_wentry_q;
        rd_entry_d   = rd_entry_q;
        res_found_d  = res_found_q;
        res_idx_d    = res_idx_q;
        done_d       = 1'b0;
        ine_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = ((req_op == 3'd4) && (inv_op <= 5'd6)) ? S_WALK : S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                case (op_q)
                    3'd0: begin
                        res_found_d = srch_found;
                        if (srch_found) begin
                            res_idx_d = srch_idx;
                        end
                    end
                    3'd1: begin
                        rd_entry_d  = entrys[csr_idx_q];
                        res_found_d = entrys[csr_idx_q].e;
                    end
                    3'd2: begin
                        tlb_we_d     = 1'b1;
                        tlb_widx_d   = csr_idx_q;
                        tlb_wentry_d = csr_entry_q;
                    end
                    3'd3: begin
                        tlb_we_d     = 1'b1;
                        tlb_widx_d   = fill_cnt_q;
                        tlb_wentry_d = csr_entry_q;
                    end
                    default: ine_d = 1'b1;
                endcase
            end
            S_WALK: begin
                if (inv_hit) begin
                    tlb_we_d       = 1'b1;
                    tlb_widx_d     = walk_cnt_q;
                    tlb_wentry_d   = walk_ent;
                    tlb_wentry_d.e = 1'b0;
                end
                if (walk_cnt_q == LAST_IDX) begin
                    walk_cnt_d = '0;
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                end else begin
                    walk_cnt_d = walk_cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, walk pointer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            walk_cnt_q   <= '0;
            tlb_we_q     <= 1'b0;
            tlb_widx_q   <= '0;
            tlb_wentry_q <= '0;
            rd_entry_q   <= '0;
            res_found_q  <= 1'b0;
            res_idx_q    <= '0;
            done_q       <= 1'b0;
            ine_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            walk_cnt_q   <= walk_cnt_d;
            tlb_we_q     <= tlb_we_d;
            tlb_widx_q   <= tlb_widx_d;
            tlb_wentry_q <= tlb_wentry_d;
            rd_entry_q   <= rd_entry_d;
            res_found_q  <= res_found_d;
            res_idx_q    <= res_idx_d;
            done_q       <= done_d;
            ine_q        <= ine_d;
        end
    end

    // Request fields are captured only on accept so the MEM stage may move on afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= '0;
            inv_op_q    <= '0;
            inv_asid_q  <= '0;
            inv_vppn_q  <= '0;
            csr_idx_q   <= '0;
            csr_entry_q <= '0;
        end else if (accept) begin
            op_q        <= req_op;
            inv_op_q    <= inv_op;
            inv_asid_q  <= inv_asid;
            inv_vppn_q  <= inv_va[31:13];
            csr_idx_q   <= csr_idx;
            csr_entry_q <= csr_entry;
        end
    end

    // TLBFILL victim pointer: free-running round robin, independent of pipeline activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt_q <= '0;
        end else begin
            fill_cnt_q <= (fill_cnt_q == LAST_IDX) ? '0 : fill_cnt_q + 1'b1;
        end
    end

endmodule
